// File: rtl/sum_divider18.sv
// sum_divider18: sequential restoring divider that maps a signed adder-tree
// sum onto the signed operand range of the neuron datapath.
// It produces one quotient bit per cycle, saturates the quotient, and gives
// the remainder the sign of the dividend. Both sides use valid/ready handshakes.
// Optional feature macro: SUM_DIVIDER_ROUND_EN (round half away from zero).
module sum_divider18 #(
    parameter int DW = 18,
    parameter int VW = 9,
    parameter int QW = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [QW-1:0] quotient,
    output logic [DW-1:0] remainder,
    output logic          ovf,
    output logic          div_zero
);

    localparam int CW = $clog2(DW + 1);
    localparam int XW = DW + 2;
    localparam logic signed [XW-1:0] QMAX = XW'((2 ** (QW - 1)) - 1);
    localparam logic signed [XW-1:0] QMIN = XW'(-(2 ** (QW - 1)));

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_mag;
    logic [DW-1:0] r_rem;
    logic [DW-1:0] r_quo;
    logic [VW-1:0] r_div;
    logic          r_neg;
    logic          r_dz;
    logic [QW-1:0] r_q;
    logic [DW-1:0] r_r;
    logic          r_ovf;
    logic          r_dzo;

    logic                 w_accept;
    logic                 w_last;
    logic [DW-1:0]        w_abs;
    logic [DW-1:0]        w_div_x;
    logic [DW-1:0]        w_rem_sh;
    logic                 w_ge;
    logic [DW-1:0]        w_rem_nx;
    logic                 w_round_up;
    logic signed [XW-1:0] w_qmag;
    logic signed [XW-1:0] w_qs;
    logic [DW-1:0]        w_rmag;
    logic [DW-1:0]        w_rs;
    logic [DW-1:0]        w_mag_sgn;

    assign w_accept = in_valid && (r_state == IDLE);
    assign w_last   = (r_cnt == CW'(DW));

    // |dividend| fits in DW unsigned bits, including the most negative value
    assign w_abs   = dividend[DW-1] ? (~dividend + DW'(1)) : dividend;
    assign w_div_x = {{(DW - VW){1'b0}}, r_div};

    // The partial remainder is always below the divisor, so dropping its
    // top bit before the shift never loses information.
    assign w_rem_sh = {r_rem[DW-2:0], r_mag[DW-1]};
    assign w_ge     = (w_rem_sh >= w_div_x);
    assign w_rem_nx = w_ge ? (w_rem_sh - w_div_x) : w_rem_sh;

`ifdef SUM_DIVIDER_ROUND_EN
    assign w_round_up = ({r_rem, 1'b0} >= {1'b0, w_div_x});
`else
    assign w_round_up = 1'b0;
`endif

    assign w_qmag    = {2'b00, r_quo} + XW'(w_round_up);
    assign w_qs      = r_neg ? -w_qmag : w_qmag;
    assign w_rmag    = r_rem - (w_round_up ? w_div_x : '0);
    assign w_rs      = r_neg ? (~w_rmag + DW'(1)) : w_rmag;
    assign w_mag_sgn = r_neg ? (~r_mag + DW'(1)) : r_mag;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign quotient  = r_q;
    assign remainder = r_r;
    assign ovf       = r_ovf;
    assign div_zero  = r_dzo;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = CALC;
            CALC:    if (w_last) w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Operand capture, one restoring step per CALC cycle, and result finalisation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_mag <= '0;
            r_rem <= '0;
            r_quo <= '0;
            r_div <= '0;
            r_neg <= 1'b0;
            r_dz  <= 1'b0;
            r_q   <= '0;
            r_r   <= '0;
            r_ovf <= 1'b0;
            r_dzo <= 1'b0;
        end else if (w_accept) begin
            r_mag <= w_abs;
            r_neg <= dividend[DW-1];
            r_div <= divisor;
            r_dz  <= (divisor == '0);
            r_rem <= '0;
            r_quo <= '0;
            // A zero divisor preloads the counter to skip the iterations, so it
            // still spends one cycle in CALC and the result appears one edge
            // after acceptance.
            r_cnt <= (divisor == '0) ? CW'(DW) : '0;
        end else if (r_state == CALC) begin
            if (!w_last) begin
                r_rem <= w_rem_nx;
                r_quo <= {r_quo[DW-2:0], w_ge};
                r_mag <= {r_mag[DW-2:0], 1'b0};
                r_cnt <= r_cnt + CW'(1);
            end else if (r_dz) begin
                r_q   <= r_neg ? QMIN[QW-1:0] : QMAX[QW-1:0];
                r_r   <= w_mag_sgn;
                r_ovf <= 1'b1;
                r_dzo <= 1'b1;
            end else begin
                if (w_qs > QMAX) begin
                    r_q   <= QMAX[QW-1:0];
                    r_ovf <= 1'b1;
                end else if (w_qs < QMIN) begin
                    r_q   <= QMIN[QW-1:0];
                    r_ovf <= 1'b1;
                end else begin
                    r_q   <= w_qs[QW-1:0];
                    r_ovf <= 1'b0;
                end
                r_r   <= w_rs;
                r_dzo <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sum_divider18.sv
// tb_sum_divider18: directed and random operations on sum_divider18, checked
// against an integer-arithmetic reference of signed divide with saturation.
module tb_sum_divider18;

    localparam int DW = 18;
    localparam int VW = 9;
    localparam int QW = 17;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [QW-1:0] quotient;
    logic [DW-1:0] remainder;
    logic          ovf;
    logic          div_zero;

    int n_vec = 0;
    int n_err = 0;

    sum_divider18 #(.DW(DW), .VW(VW), .QW(QW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder),
        .ovf       (ovf),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division on magnitudes, then sign and clamp
    function automatic void model(input int dvd, input int dsr,
                                  output logic [QW-1:0] q, output logic [DW-1:0] r,
                                  output logic o, output logic z);
        int a, qq, rr, sq, sr;
        if (dsr == 0) begin
            z = 1'b1;
            o = 1'b1;
            q = (dvd >= 0) ? QW'(65535) : QW'(-65536);
            r = DW'(dvd);
        end else begin
            z  = 1'b0;
            a  = (dvd < 0) ? -dvd : dvd;
            qq = a / dsr;
            rr = a - qq * dsr;
`ifdef SUM_DIVIDER_ROUND_EN
            if (2 * rr >= dsr) begin
                qq = qq + 1;
                rr = a - qq * dsr;
            end
`endif
            sq = (dvd < 0) ? -qq : qq;
            sr = (dvd < 0) ? -rr : rr;
            if (sq > 65535) begin
                q = QW'(65535);
                o = 1'b1;
            end else if (sq < -65536) begin
                q = QW'(-65536);
                o = 1'b1;
            end else begin
                q = QW'(sq);
                o = 1'b0;
            end
            r = DW'(sr);
        end
    endfunction

    // One full operation: accept, wait (bounded) for the result, hold, handshake
    task automatic run_op(input int dvd, input int dsr, input int hold, input bit early);
        logic [QW-1:0] eq;
        logic [DW-1:0] er;
        logic eo, ez;
        int k;
        int exp_lat;
        model(dvd, dsr, eq, er, eo, ez);
        exp_lat = (dsr == 0) ? 1 : DW + 1;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'(1));
        dividend  = DW'(dvd);
        divisor   = VW'(dsr);
        in_valid  = 1'b1;
        out_ready = early;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = VW'($urandom);
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            k++;
            @(negedge clk);
        end
        check("latency", 32'(k), 32'(exp_lat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("ovf", 32'(ovf), 32'(eo));
        check("div_zero", 32'(div_zero), 32'(ez));
        check("in_ready_busy", 32'(in_ready), 32'(0));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                in_valid = 1'($urandom);
                dividend = DW'($urandom);
                divisor  = VW'($urandom);
                @(posedge clk);
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'(1));
                check("hold_in_ready", 32'(in_ready), 32'(0));
                check("hold_quotient", 32'(quotient), 32'(eq));
                check("hold_remainder", 32'(remainder), 32'(er));
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("in_ready_after", 32'(in_ready), 32'(1));
        check("out_valid_after", 32'(out_valid), 32'(0));
    endtask

    initial begin
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_ovf", 32'(ovf), 32'(0));
        check("rst_div_zero", 32'(div_zero), 32'(0));
        rst_n = 1'b1;

        run_op(37, 5, 0, 1'b0);
        run_op(-37, 5, 0, 1'b0);
        run_op(38, 5, 0, 1'b0);
        run_op(-38, 5, 0, 1'b0);
        run_op(131071, 1, 0, 1'b0);
        run_op(-131072, 1, 0, 1'b0);
        run_op(-131072, 4, 0, 1'b0);
        run_op(100, 0, 0, 1'b0);
        run_op(-5, 0, 0, 1'b0);
        run_op(0, 7, 0, 1'b1);
        run_op(12345, 511, 10, 1'b0);
        run_op(-99999, 3, 2, 1'b1);

        // Reset during CALC iteration 9 aborts the operation
        @(negedge clk);
        dividend = DW'(37);
        divisor  = VW'(5);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'(0));
        check("abort_in_ready", 32'(in_ready), 32'(1));
        check("abort_quotient", 32'(quotient), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < DW + 6; c++) begin
            @(negedge clk);
            check("abort_no_result", 32'(out_valid), 32'(0));
        end
        run_op(20, 3, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            int d;
            int v;
            int sel;
            d   = int'($urandom_range(0, 262143)) - 131072;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      v = 0;
            else if (sel == 1) v = int'($urandom_range(1, 3));
            else               v = int'($urandom_range(1, 511));
            run_op(d, v, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
